axi_log_drain_ctrl: RTL
=======================

Name: axi_log_drain_ctrl

Overview:
Sequences the AXI BRAM logger through its capture, drain and clear phases.
- Keeps a mirror of the logger's entry count by snooping the handshakes it logs.
- On a software start (or automatically when the logger is full), it gates logging off and reads every valid entry out of the logger's 32-bit BRAM slave port as 3 words per entry.
- Streams those words over a valid/ready interface to the host-side DMA/FIFO, then issues Clear and waits for the logger's clear sweep to finish before re-enabling logging.

Parameters:
- NUM_SER_BRAMS, 12, serial BRAM depth of the logger; DEPTH = 1024*NUM_SER_BRAMS entries.
- WORDS_PER_ENTRY, 3, 32-bit words per log entry (96-bit entry).
- CNT_BITW, 14, entry counter width; must be >= log2(DEPTH)+1.
- CLEAR_CYCLES, 12290, cycles to wait after the Clear pulse (DEPTH + 2).

Ports:
- Clk_CI, in, 1, clock.
- Rst_RBI, in, 1, asynchronous active-low reset.
- AxiValid_SI, in, 1, snooped AXI valid of the logged channel.
- AxiReady_SI, in, 1, snooped AXI ready of the logged channel.
- Full_SI, in, 1, logger Full_SO.
- Start_SI, in, 1, single-cycle drain request from the config register.
- LogEn_SO, out, 1, logging enable; the upstream ANDs it into the logger's AxiValid.
- Clear_SO, out, 1, one-cycle clear pulse to the logger.
- BramEn_SO, out, 1, BRAM port enable.
- BramAddr_DO, out, 32, byte address = word index << 2.
- BramWrEn_SO, out, 4, tied 0.
- BramRd_DI, in, 32, BRAM read data, valid 1 cycle after BramEn_SO.
- Data_DO, out, 32, drained word.
- Valid_SO, out, 1, stream valid.
- Ready_SI, in, 1, stream ready.
- Busy_SO, out, 1, high in any state except IDLE.
- Done_SO, out, 1, one-cycle pulse when the clear wait completes.
- Entries_DO, out, CNT_BITW, current mirror count.

Behaviour:
Reset values (asynchronous, Rst_RBI low):
- State IDLE; LogEn_SO=1; all other outputs 0; mirror count 0; output buffer empty.

Mirror count:
- In IDLE, increments on AxiValid_SI & AxiReady_SI & LogEn_SO.
- Saturates at DEPTH-1.
- Drain length N = mirror count, latched on leaving IDLE.

FSM states: IDLE, DRAIN, FLUSH, CLEAR, CLEAR_WAIT.
- IDLE -> DRAIN when a trigger occurs and N>0.
  - Trigger is Start_SI (or the auto trigger, see Optional Feature).
  - LogEn_SO drops in the same cycle the trigger is seen.
- IDLE -> CLEAR when a trigger occurs and N=0. This path emits no words.
- DRAIN: word index w runs 0..N*WORDS_PER_ENTRY-1.
  - Each issued read drives BramEn_SO=1 and BramAddr_DO=w<<2.
  - Read data returns one cycle later into a 2-entry output FIFO.
  - A read issues only when FIFO occupancy + reads in flight < 2. No word is ever dropped or duplicated under backpressure.
  - With Ready_SI held high, throughput is 1 word/cycle.
  - Words are emitted in address order: entry e gives word0 = timestamp, word1 = AXI address, word2 = {len,id} as laid out by the logger.
- DRAIN -> FLUSH when the last read has issued.
- FLUSH -> CLEAR when the FIFO is empty and no read is in flight.
- CLEAR: Clear_SO=1 for exactly one cycle; load the wait counter with CLEAR_CYCLES; mirror count reset to 0. Next state is CLEAR_WAIT.
- CLEAR_WAIT: count down to 0, then Done_SO=1 for one cycle, LogEn_SO=1, state IDLE.

Stream protocol:
- Valid_SO, once high, stays high with Data_DO stable until Ready_SI.
- Transfer occurs on Valid_SO & Ready_SI.

Boundary and overlap rules:
- Start_SI outside IDLE is ignored.
- A snooped handshake in the trigger cycle is still counted.
- Handshakes while LogEn_SO=0 are not counted.
- Full_SI while busy is ignored.
- Reset mid-drain returns to IDLE immediately. The logger is not cleared, and the mirror count is lost (software must issue a start, which drains 0 entries and clears).

Optional Feature:
Macro AXI_LOG_DRAIN_AUTO_EN.
- Defined: a rising edge of Full_SI (registered edge detect) in IDLE is a trigger, identical to Start_SI.
- Undefined: Full_SI is ignored and the drain starts only on Start_SI; the edge-detect flop is not built.

Test Plan:
- 5 snooped handshakes, Start_SI, Ready_SI=1 -> Entries_DO=5.
  - Exactly 15 words on the stream in consecutive cycles, BramAddr_DO=0x00,0x04,...,0x38.
  - Then one Clear_SO pulse, Done_SO 12290 cycles later, LogEn_SO=1.
- 2 entries drained with Ready_SI toggling 1,0,0,1 repeating -> all 6 words delivered in order, no duplicates, Data_DO stable while stalled.
- Start_SI with count 0 -> no BramEn_SO, Clear_SO pulse on the next cycle, Done_SO after the wait.
- Handshake in the same cycle as Start_SI, plus further handshakes during DRAIN -> the first is counted (N includes it), later ones are not; after Done_SO, Entries_DO=0.
- Assert Rst_RBI low while word 4 of 9 is pending -> all outputs at reset values asynchronously, no Clear_SO; LogEn_SO=1.
- With AXI_LOG_DRAIN_AUTO_EN defined, Full_SI 0->1 at count 11263 -> drain of 33789 words starts automatically. With the macro undefined, the same stimulus leaves the state in IDLE.

Source files
------------

// File: rtl/axi_log_drain_ctrl_if.sv
// Bus bundle between the drain controller, the logger's 32-bit BRAM slave port
// and the host-side word stream.
interface axi_log_drain_ctrl_if;
  logic        BramEn_SO;
  logic [31:0] BramAddr_DO;
  logic [3:0]  BramWrEn_SO;
  logic [31:0] BramRd_DI;
  logic [31:0] Data_DO;
  logic        Valid_SO;
  logic        Ready_SI;

  modport master (
    output BramEn_SO, BramAddr_DO, BramWrEn_SO, Data_DO, Valid_SO,
    input  BramRd_DI, Ready_SI
  );

  modport slave (
    input  BramEn_SO, BramAddr_DO, BramWrEn_SO, Data_DO, Valid_SO,
    output BramRd_DI, Ready_SI
  );
endinterface

// File: rtl/axi_log_drain_ctrl.sv
// Capture/drain/clear sequencer for the AXI BRAM logger.
// Define AXI_LOG_DRAIN_AUTO_EN to also start a drain on a rising edge of Full_SI.
module axi_log_drain_ctrl #(
  parameter int NUM_SER_BRAMS   = 12,
  parameter int WORDS_PER_ENTRY = 3,
  parameter int CNT_BITW        = 14,
  parameter int CLEAR_CYCLES    = 12290
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 AxiValid_SI,
  input  logic                 AxiReady_SI,
  input  logic                 Full_SI,
  input  logic                 Start_SI,
  output logic                 LogEn_SO,
  output logic                 Clear_SO,
  output logic                 Busy_SO,
  output logic                 Done_SO,
  output logic [CNT_BITW-1:0]  Entries_DO,
  axi_log_drain_ctrl_if.master Bus_M
);
  localparam int DEPTH  = 1024 * NUM_SER_BRAMS;
  localparam int WIDX_W = CNT_BITW + $clog2(WORDS_PER_ENTRY + 1);
  localparam int WAIT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_BITW-1:0] CNT_MAX = CNT_BITW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, CLEAR, CLEAR_WAIT} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITW-1:0] cnt_q, cnt_d;
  logic [WIDX_W-1:0]   words_q, words_d;
  logic [WIDX_W-1:0]   w_q, w_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                infl_q;
  logic [1:0]          occ_q, occ_d;
  logic                wr_ptr_q, rd_ptr_q;
  logic [31:0]         mem_q [2];
  logic                trig, issue, pop;

`ifdef AXI_LOG_DRAIN_AUTO_EN
  logic full_q;
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) full_q <= 1'b0;
    else          full_q <= Full_SI;
  end
  assign trig = Start_SI | (Full_SI & ~full_q);
`else
  logic unused_full;
  assign unused_full = Full_SI;
  assign trig        = Start_SI;
`endif

  // Occupancy after this cycle's pop and returning read; a new read may only
  // be issued while that leaves room for it, so nothing can overflow.
  assign pop   = Bus_M.Valid_SO & Bus_M.Ready_SI;
  assign occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};

  assign Bus_M.Valid_SO    = (occ_q != 2'd0);
  assign Bus_M.Data_DO     = mem_q[rd_ptr_q];
  assign Bus_M.BramEn_SO   = issue;
  assign Bus_M.BramAddr_DO = issue ? (32'(w_q) << 2) : 32'd0;
  assign Bus_M.BramWrEn_SO = 4'd0;
  assign Busy_SO           = (state_q != IDLE);
  assign Entries_DO        = cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    w_d       = w_q;
    wait_d    = wait_q;
    issue     = 1'b0;
    LogEn_SO  = 1'b0;
    Clear_SO  = 1'b0;
    Done_SO   = 1'b0;
    unique case (state_q)
      IDLE: begin
        LogEn_SO = ~trig;
        // The handshake in the trigger cycle still counts toward N.
        if (AxiValid_SI && AxiReady_SI && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_BITW'(1);
        if (trig) begin
          words_d = WIDX_W'(cnt_d) * WIDX_W'(WORDS_PER_ENTRY);
          w_d     = '0;
          state_d = (cnt_d != '0) ? DRAIN : CLEAR;
        end
      end
      DRAIN: begin
        issue = (occ_d < 2'd2);
        if (issue) begin
          w_d = w_q + WIDX_W'(1);
          if (w_q == words_q - WIDX_W'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (occ_q == 2'd0 && !infl_q) state_d = CLEAR;
      end
      CLEAR: begin
        Clear_SO = 1'b1;
        wait_d   = WAIT_W'(CLEAR_CYCLES);
        cnt_d    = '0;
        state_d  = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        if (wait_q <= WAIT_W'(1)) begin
          Done_SO = 1'b1;
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      words_q  <= '0;
      w_q      <= '0;
      wait_q   <= '0;
      infl_q   <= 1'b0;
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= 32'd0;
      mem_q[1] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      w_q     <= w_d;
      wait_q  <= wait_d;
      infl_q  <= issue;
      occ_q   <= occ_d;
      if (infl_q) begin
        mem_q[wr_ptr_q] <= Bus_M.BramRd_DI;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end
endmodule
